// File: rtl/int_ram_arb_if.sv
// Bus bundle between the internal-RAM arbiter, its two requesters (CPU and
// external programming port) and the single-port RAM.
`ifndef RW
`define RW 16
`endif

interface int_ram_arb_if #(
  parameter int DATA_W = `RW
);
  logic              i_cpu_hold;
  logic              i_c_req;
  logic              i_c_we;
  logic [5:0]        i_c_addr;
  logic [DATA_W-1:0] i_c_data;
  logic              o_c_ack;
  logic [DATA_W-1:0] o_c_data;

  logic              i_e_req;
  logic              i_e_we;
  logic [5:0]        i_e_addr;
  logic [DATA_W-1:0] i_e_data;
  logic              o_e_ack;
  logic [DATA_W-1:0] o_e_data;

  logic [5:0]        o_ram_addr;
  logic [DATA_W-1:0] o_ram_data;
  logic              o_ram_we;
  logic [DATA_W-1:0] i_ram_data;

  modport slave (
    input  i_cpu_hold,
    input  i_c_req, i_c_we, i_c_addr, i_c_data,
    output o_c_ack, o_c_data,
    input  i_e_req, i_e_we, i_e_addr, i_e_data,
    output o_e_ack, o_e_data,
    output o_ram_addr, o_ram_data, o_ram_we,
    input  i_ram_data
  );

  modport master (
    output i_cpu_hold,
    output i_c_req, i_c_we, i_c_addr, i_c_data,
    input  o_c_ack, o_c_data,
    output i_e_req, i_e_we, i_e_addr, i_e_data,
    input  o_e_ack, o_e_data,
    input  o_ram_addr, o_ram_data, o_ram_we,
    output i_ram_data
  );
endinterface

// File: rtl/int_ram_arb.sv
// Two-port arbiter for a single-port internal RAM: CPU has priority, with a
// bounded CPU burst so a waiting external request is never starved.
module int_ram_arb #(
  parameter int MAX_CPU_BURST = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  int_ram_arb_if.slave bus
);

  localparam int SW = (MAX_CPU_BURST > 0) ? $clog2(MAX_CPU_BURST + 1) : 1;
  localparam logic [SW-1:0] BURST_MAX = SW'(MAX_CPU_BURST);

  typedef enum logic {IDLE, RESP} state_e;
  typedef enum logic {OWN_CPU, OWN_EXT} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] starv_q, starv_d;
  logic          c_qual, cpu_win, ext_win;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    starv_d         = starv_q;
    c_qual          = bus.i_c_req & ~bus.i_cpu_hold;
    cpu_win         = 1'b0;
    ext_win         = 1'b0;
    bus.o_ram_addr  = '0;
    bus.o_ram_data  = '0;
    bus.o_ram_we    = 1'b0;
    bus.o_c_ack     = 1'b0;
    bus.o_c_data    = '0;
    bus.o_e_ack     = 1'b0;
    bus.o_e_data    = '0;

    // Reset cycles neither grant nor acknowledge; an in-flight access is dropped.
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          cpu_win = c_qual && !(bus.i_e_req && (starv_q == BURST_MAX));
          ext_win = bus.i_e_req && !cpu_win;
          if (cpu_win) begin
            bus.o_ram_addr = bus.i_c_addr;
            bus.o_ram_data = bus.i_c_data;
            bus.o_ram_we   = bus.i_c_we;
            owner_d        = OWN_CPU;
            state_d        = RESP;
          end else if (ext_win) begin
            bus.o_ram_addr = bus.i_e_addr;
            bus.o_ram_data = bus.i_e_data;
            bus.o_ram_we   = bus.i_e_we;
            owner_d        = OWN_EXT;
            state_d        = RESP;
          end
          // Counter only tracks CPU wins over a waiting external request.
          if (ext_win || !bus.i_e_req) begin
            starv_d = '0;
          end else if (cpu_win && (starv_q != BURST_MAX)) begin
            starv_d = starv_q + SW'(1);
          end
        end
        RESP: begin
          state_d = IDLE;
          if (owner_q == OWN_CPU) begin
            bus.o_c_ack  = 1'b1;
            bus.o_c_data = bus.i_ram_data;
          end else begin
            bus.o_e_ack  = 1'b1;
            bus.o_e_data = bus.i_ram_data;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      starv_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      starv_q <= starv_d;
    end
  end

endmodule

// File: tb/tb_int_ram_arb.sv
// Bench for int_ram_arb: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the arbitration rules.
module tb_int_ram_arb;

  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int_ram_arb_if #(.DATA_W(16)) bus ();

  int_ram_arb #(.MAX_CPU_BURST(MAX)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: address/data/we sampled on the edge, read data registered.
  logic [15:0] mem [64] = '{default: 16'h0};
  always @(posedge clk) begin
    bus.i_ram_data <= mem[bus.o_ram_addr];
    if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] ref_mem [64] = '{default: 16'h0};
  bit          m_busy  = 1'b0;
  bit          m_owner = 1'b0;
  int          m_burst = 0;
  logic [15:0] m_rdata = 16'h0;

  logic        obs_c_ack, obs_e_ack, obs_ram_we;
  logic [5:0]  obs_ram_addr;
  logic [15:0] obs_ram_data, obs_c_data, obs_e_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic        x_cack, x_eack, x_we;
    logic [5:0]  x_addr;
    logic [15:0] x_wd, x_cd, x_ed;
    bit          cw, ew;
    @(negedge clk);
    x_cack = 0; x_eack = 0; x_we = 0; x_addr = '0; x_wd = '0; x_cd = '0; x_ed = '0;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_burst = 0;
    end else if (m_busy) begin
      if (!m_owner) begin x_cack = 1; x_cd = m_rdata; end
      else          begin x_eack = 1; x_ed = m_rdata; end
      m_busy = 0;
    end else begin
      cw = bus.i_c_req && !bus.i_cpu_hold && !(bus.i_e_req && m_burst == MAX);
      ew = bus.i_e_req && !cw;
      if (cw) begin
        x_addr = bus.i_c_addr; x_wd = bus.i_c_data; x_we = bus.i_c_we; m_owner = 0;
      end else if (ew) begin
        x_addr = bus.i_e_addr; x_wd = bus.i_e_data; x_we = bus.i_e_we; m_owner = 1;
      end
      if (cw || ew) begin
        m_busy  = 1;
        m_rdata = ref_mem[x_addr];
        if (x_we) ref_mem[x_addr] = x_wd;
      end
      if (!bus.i_e_req || ew) m_burst = 0;
      else if (cw && m_burst < MAX) m_burst++;
    end
    obs_c_ack = bus.o_c_ack;   obs_e_ack = bus.o_e_ack;   obs_ram_we = bus.o_ram_we;
    obs_ram_addr = bus.o_ram_addr; obs_ram_data = bus.o_ram_data;
    obs_c_data = bus.o_c_data; obs_e_data = bus.o_e_data;
    check_eq("c_ack",    obs_c_ack,    x_cack);
    check_eq("e_ack",    obs_e_ack,    x_eack);
    check_eq("ram_we",   obs_ram_we,   x_we);
    check_eq("ram_addr", obs_ram_addr, x_addr);
    check_eq("ram_data", obs_ram_data, x_wd);
    check_eq("c_data",   obs_c_data,   x_cd);
    check_eq("e_data",   obs_e_data,   x_ed);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks[$];
    int nc, ne, nwe, got;
    bus.i_cpu_hold = 0;
    bus.i_c_req = 0; bus.i_c_we = 0; bus.i_c_addr = '0; bus.i_c_data = '0;
    bus.i_e_req = 0; bus.i_e_we = 0; bus.i_e_addr = '0; bus.i_e_data = '0;

    // Reset with requests present: nothing granted
    bus.i_c_req = 1; bus.i_e_req = 1;
    step(); step();
    check_eq("rst_c_ack", obs_c_ack, 0);
    check_eq("rst_e_ack", obs_e_ack, 0);
    check_eq("rst_we",    obs_ram_we, 0);
    bus.i_c_req = 0; bus.i_e_req = 0;
    rst = 0;
    step();

    // External write then read-back
    bus.i_e_req = 1; bus.i_e_we = 1; bus.i_e_addr = 6'd5; bus.i_e_data = 16'hBEEF;
    step();
    check_eq("ewr_grant_addr", obs_ram_addr, 5);
    check_eq("ewr_grant_we",   obs_ram_we, 1);
    step();
    check_eq("ewr_ack", obs_e_ack, 1);
    bus.i_e_we = 0;
    step();
    step();
    check_eq("erd_ack",  obs_e_ack, 1);
    check_eq("erd_data", obs_e_data, 16'hBEEF);
    check_eq("erd_cack", obs_c_ack, 0);
    bus.i_e_req = 0;
    step();

    // Simultaneous requests: CPU first, external next
    bus.i_c_req = 1; bus.i_c_we = 0; bus.i_c_addr = 6'd12;
    bus.i_e_req = 1; bus.i_e_we = 0; bus.i_e_addr = 6'd5;
    step();
    check_eq("sim_cpu_addr", obs_ram_addr, 12);
    step();
    check_eq("sim_cpu_ack", obs_c_ack, 1);
    bus.i_c_req = 0;
    step();
    check_eq("sim_ext_addr", obs_ram_addr, 5);
    step();
    check_eq("sim_ext_ack", obs_e_ack, 1);
    bus.i_e_req = 0;
    step();

    // CPU burst limit with an external request waiting
    bus.i_c_req = 1; bus.i_c_addr = 6'($urandom);
    bus.i_e_req = 1; bus.i_e_addr = 6'd9;
    for (int k = 0; k < 30 && acks.size() < 6; k++) begin
      step();
      if (obs_c_ack) begin acks.push_back(0); bus.i_c_addr = 6'($urandom); end
      if (obs_e_ack) begin acks.push_back(1); bus.i_e_req = 0; end
    end
    bus.i_c_req = 0; bus.i_e_req = 0;
    check_eq("burst_n", acks.size(), 6);
    for (int i = 0; i < 6; i++)
      check_eq("burst_seq", (i < acks.size()) ? acks[i] : 2, (i == 4) ? 1 : 0);
    step();

    // CPU hold: CPU write request held, external reads proceed
    bus.i_cpu_hold = 1;
    bus.i_c_req = 1; bus.i_c_we = 1; bus.i_c_addr = 6'd20; bus.i_c_data = 16'h1234;
    nc = 0; ne = 0; nwe = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      nc += obs_c_ack; ne += obs_e_ack; nwe += obs_ram_we;
      if (obs_e_ack) bus.i_e_req = 0;
      else if (!bus.i_e_req) begin bus.i_e_req = 1; bus.i_e_we = 0; bus.i_e_addr = 6'($urandom); end
    end
    bus.i_e_req = 0;
    check_eq("hold_c_acks", nc, 0);
    check_eq("hold_we", nwe, 0);
    check_eq("hold_e_seen", ne > 0, 1);
    step(); step();
    bus.i_cpu_hold = 0;
    got = 0;
    for (int k = 0; k < 2 && !got; k++) begin
      step();
      if (obs_c_ack) got = 1;
    end
    check_eq("hold_release_ack", got, 1);
    bus.i_c_req = 0; bus.i_c_we = 0;
    step();

    // Reset during RESP of a CPU read
    bus.i_c_req = 1; bus.i_c_addr = 6'd7;
    step();
    rst = 1;
    step();
    check_eq("rstresp_cack", obs_c_ack, 0);
    check_eq("rstresp_addr", obs_ram_addr, 0);
    step();
    check_eq("rstresp_cack2", obs_c_ack, 0);
    rst = 0;
    step();
    check_eq("post_rst_grant", obs_ram_addr, 7);
    step();
    check_eq("post_rst_ack", obs_c_ack, 1);
    bus.i_c_req = 0;
    step();

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      step();
      if (obs_c_ack) bus.i_c_req = 0;
      if (obs_e_ack) bus.i_e_req = 0;
      if (m_busy && ($urandom % 5 == 0)) begin
        if (!m_owner) bus.i_c_req = 0; else bus.i_e_req = 0;
      end
      if (!bus.i_c_req && ($urandom % 3 == 0)) begin
        bus.i_c_req = 1; bus.i_c_we = 1'($urandom);
        bus.i_c_addr = 6'($urandom); bus.i_c_data = 16'($urandom);
      end
      if (!bus.i_e_req && ($urandom % 4 == 0)) begin
        bus.i_e_req = 1; bus.i_e_we = 1'($urandom);
        bus.i_e_addr = 6'($urandom); bus.i_e_data = 16'($urandom);
      end
      if ($urandom % 25 == 0) bus.i_cpu_hold = ~bus.i_cpu_hold;
      rst = ($urandom % 70 == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ram_arb.md
INT_RAM_ARB -- requirements
Module: int_ram_arb

Interface
REQ-001 SHALL have parameter MAX_CPU_BURST, default 4: max consecutive CPU grants while an external request waits.
REQ-002 SHALL have port i_clk  input  1  single clock for all logic.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous to i_clk, active-high.
REQ-004 SHALL have port i_cpu_hold  input  1  embed/programming mode; when 1, CPU requests are never granted.
REQ-005 SHALL have ports i_c_req / i_c_we  input  1 each  CPU request, held until ack / write enable.
REQ-006 SHALL have ports i_c_addr  input  6  and i_c_data  input  `RW  CPU word address and write data.
REQ-007 SHALL have ports o_c_ack  output  1  and o_c_data  output  `RW  CPU completion pulse and read data.
REQ-008 SHALL have ports i_e_req, i_e_we (input, 1), i_e_addr (input, 6), i_e_data (input, `RW)  external programming port, same semantics as CPU port.
REQ-009 SHALL have ports o_e_ack (output, 1) and o_e_data (output, `RW)  external completion pulse and read data.
REQ-010 SHALL have ports o_ram_addr (output, 6), o_ram_data (output, `RW), o_ram_we (output, 1), i_ram_data (input, `RW)  RAM side; RAM samples address/data/we on the rising edge and returns registered read data one cycle later.

Function
REQ-011 SHALL implement states IDLE and RESP; in IDLE an access is granted in the same cycle a qualified request is seen.
REQ-012 SHALL, in the grant cycle, drive o_ram_addr/o_ram_data/o_ram_we combinationally from the winner, latch the owner, and move to RESP.
REQ-013 SHALL, in RESP, assert the owner's ack for exactly one cycle, drive owner's o_*_data = i_ram_data, then return to IDLE.
REQ-014 SHALL take exactly one cycle from grant to ack; max throughput = one access per 2 cycles; no grant in RESP.
REQ-015 SHALL hold o_ram_we=0, o_ram_addr=0, o_ram_data=0 in any cycle without a grant (including RESP).
REQ-016 SHALL drive non-owner o_*_data = 0 and non-owner ack = 0 at all times.
REQ-017 SHALL, on a write, return old RAM contents on o_*_data in RESP; requesters ignore data on writes.
REQ-018 SHALL qualify a CPU request only when i_c_req=1 and i_cpu_hold=0.
REQ-019 SHALL grant CPU over external when both are qualified, unless the starvation counter equals MAX_CPU_BURST.
REQ-020 SHALL increment a starvation counter (width ceil(log2(MAX_CPU_BURST+1))) on each CPU grant while i_e_req=1, saturating at MAX_CPU_BURST.
REQ-021 SHALL clear the starvation counter on any external grant and in any IDLE cycle where i_e_req=0.
REQ-022 SHALL complete a granted access (ack pulse in RESP) even if the requester drops its request in RESP.
REQ-023 SHALL sample i_cpu_hold only at grant time; a CPU access already in RESP completes when hold rises.
REQ-024 SHALL never assert both acks in the same cycle.

Reset
REQ-025 SHALL, while i_rst=1 at a rising edge, enter IDLE, clear owner and starvation counter; outputs in the following cycle: acks 0, o_ram_we 0, o_ram_addr 0, data outputs 0.
REQ-026 SHALL abort an in-flight access on reset mid-RESP with no ack; a write issued in the grant cycle is not undone.
REQ-027 SHALL ignore requests during reset cycles and start granting in the first cycle after i_rst falls.

Verification
REQ-028 SHALL cover: ext write addr 5 data 0xBEEF, then ext read addr 5 -> o_e_ack one cycle after each grant, read o_e_data=0xBEEF, o_c_ack stays 0.
REQ-029 SHALL cover: c_req and e_req rise in the same cycle, hold=0 -> CPU granted first (o_ram_addr=i_c_addr), o_c_ack next cycle; ext granted in the following IDLE.
REQ-030 SHALL cover: CPU requests continuously, e_req held, MAX_CPU_BURST=4 -> exactly 4 CPU acks, then 1 ext ack, then CPU resumes.
REQ-031 SHALL cover: i_cpu_hold=1 with c_req held 20 cycles -> no o_c_ack, o_ram_we=0; ext accesses still acked; hold drops -> CPU acked within 2 cycles.
REQ-032 SHALL cover: i_rst asserted in RESP of a CPU read -> no o_c_ack that cycle or after, all outputs 0, clean grant after reset deasserts.
